ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and resolves operand forwarding, decodes ALUOp/funct, and computes the ALU result, the RegDst destination and the branch target. It owns the HI/LO registers and an iterative multiply/divide unit (MDU), and raises `stall` to freeze PC, IF/ID and ID/EX while an HI/LO consumer waits on a busy MDU. Results go combinationally to the EX/MEM register.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/mdu.sv | 119 +++++++++++
 rtl/ex_stage.sv | 108 ++++++++++
 tb/tb_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALUOp, funct codes, forward selects, MDU states.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative 32-step multiply/divide unit owning HI/LO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MDU_IDLE | waiting for start; HI/LO hold the last completed result
// MDU_BUSY | one shift-add / restoring-subtract step per cycle; count
//          | runs 31..0 and HI/LO are written on the edge leaving BUSY
module mdu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state;
  logic [4:0]  count;
  // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [63:0] acc;
  logic [31:0] m;
  logic        div_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic        div0_q;
  logic [31:0] dividend_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign busy  = (state == MDU_BUSY);
  assign abs_a = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (op_signed && b[31]) ? (~b + 32'd1) : b;

  // One iteration of the selected algorithm plus sign restoration of its result.
  always_comb begin
    add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    rem_shift = {acc[63:32], acc[31]};
    fits      = (rem_shift >= {1'b0, m});
    // Only used when fits; the true difference is then below m and fits 32 bits.
    diff      = rem_shift[31:0] - m;
    if (div_q) begin
      if (fits) acc_next = {diff, acc[30:0], 1'b1};
      else      acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[31:1]};
    end
    prod_fix = neg_lo_q ? (~acc_next + 64'd1) : acc_next;
    q_fix    = neg_lo_q ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    r_fix    = neg_hi_q ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
  end

  // MDU sequencer: latch magnitudes on start, iterate, commit HI/LO on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MDU_IDLE;
      count      <= 5'd0;
      acc        <= 64'd0;
      m          <= 32'd0;
      div_q      <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state      <= MDU_BUSY;
            count      <= 5'd31;
            m          <= op_div ? abs_b : abs_a;
            acc        <= {32'd0, op_div ? abs_a : abs_b};
            div_q      <= op_div;
            neg_lo_q   <= op_signed && (a[31] ^ b[31]);
            neg_hi_q   <= op_div && op_signed && a[31];
            div0_q     <= op_div && (b == 32'd0);
            dividend_q <= a;
          end
        end
        MDU_BUSY: begin
          acc <= acc_next;
          if (count == 5'd0) begin
            state <= MDU_IDLE;
            if (!div_q) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (div0_q) begin
              hi <= dividend_q;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            count <= count - 5'd1;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU, destination select, branch target, MDU stall.
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] imm,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] branch_target,
  output logic [31:0] store_data,
  output logic [4:0]  write_reg,
  output logic        stall
);

  logic [31:0] opa;
  logic [31:0] opb_fwd;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic        rtype;
  logic        mdu_op;
  logic        mdu_start;
  logic        mdu_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Forwarding muxes; code 11 falls back to the register file.
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: opa = exmem_result;
      FWD_MEMWB: opa = memwb_result;
      default:   opa = read_data1;
    endcase
    case (fwd_b)
      FWD_EXMEM: opb_fwd = exmem_result;
      FWD_MEMWB: opb_fwd = memwb_result;
      default:   opb_fwd = read_data2;
    endcase
  end

  assign opb           = alu_src ? imm : opb_fwd;
  assign store_data    = opb_fwd;
  assign shamt         = imm[10:6];
  assign write_reg     = reg_dst ? rd : rt;
  assign branch_target = pc + {imm[29:0], 2'b00};

  assign rtype     = (alu_op == ALUOP_RTYPE);
  assign mdu_op    = rtype && is_mdu_funct(funct);
  assign stall     = mdu_busy && rtype && (is_mdu_funct(funct) || is_hilo_read(funct));
  assign mdu_start = mdu_op && !mdu_busy;

  // ALU and funct decode; mult/div and unknown functs yield 0.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALUOP_SUB: alu_result = opa - opb;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_result = opa + opb;
          F_SUB, F_SUBU: alu_result = opa - opb;
          F_AND:         alu_result = opa & opb;
          F_OR:          alu_result = opa | opb;
          F_XOR:         alu_result = opa ^ opb;
          F_NOR:         alu_result = ~(opa | opb);
          F_SLT:         alu_result = {31'd0, $signed(opa) < $signed(opb)};
          F_SLTU:        alu_result = {31'd0, opa < opb};
          F_SLL:         alu_result = opb << shamt;
          F_SRL:         alu_result = opb >> shamt;
          F_SRA:         alu_result = $signed(opb) >>> shamt;
          F_MFHI:        alu_result = hi;
          F_MFLO:        alu_result = lo;
          default:       alu_result = 32'd0;
        endcase
      end
      default: alu_result = opa + opb;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // funct[1] selects divide, funct[0] selects unsigned.
  mdu u_mdu (
    .clk       (clk),
    .rst       (rst),
    .start     (mdu_start),
    .op_div    (funct[1]),
    .op_signed (~funct[0]),
    .a         (opa),
    .b         (opb_fwd),
    .busy      (mdu_busy),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues expectations, a negedge monitor checks them.
module tb_ex_stage;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  localparam int S_ALU = 0, S_ZERO = 1, S_BT = 2, S_SD = 3, S_WR = 4, S_STALL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, read_data1, read_data2, imm, exmem_result, memwb_result;
  logic [4:0]  rt, rd;
  logic [5:0]  funct;
  logic [1:0]  alu_op, fwd_a, fwd_b;
  logic        alu_src, reg_dst;
  logic [31:0] alu_result, branch_target, store_data;
  logic        zero, stall;
  logic [4:0]  write_reg;

  typedef struct {
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic obs_valid = 1'b0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .imm           (imm),
    .rt            (rt),
    .rd            (rd),
    .funct         (funct),
    .alu_op        (alu_op),
    .alu_src       (alu_src),
    .reg_dst       (reg_dst),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .exmem_result  (exmem_result),
    .memwb_result  (memwb_result),
    .alu_result    (alu_result),
    .zero          (zero),
    .branch_target (branch_target),
    .store_data    (store_data),
    .write_reg     (write_reg),
    .stall         (stall)
  );

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_ALU:   return alu_result;
      S_ZERO:  return {31'd0, zero};
      S_BT:    return branch_target;
      S_SD:    return store_data;
      S_WR:    return {27'd0, write_reg};
      default: return {31'd0, stall};
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_ALU:   return "alu_result";
      S_ZERO:  return "zero";
      S_BT:    return "branch_target";
      S_SD:    return "store_data";
      S_WR:    return "write_reg";
      default: return "stall";
    endcase
  endfunction

  // Monitor: drain every queued expectation against what the DUT presents now.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (obs_valid) begin
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = get_sig(e.sig);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h at %0t", sig_name(e.sig), act, e.exp, $time);
        end
      end
    end
  end

  task automatic expect_sig(input int s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    obs_valid = 1'b1;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    alu_op = 2'b10; funct = f; fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0;
    reg_dst = 1'b1; read_data1 = a; read_data2 = b; imm = 32'd0;
  endtask

  // Issue an MDU op, wait out the busy window holding mfhi, then read LO and HI.
  task automatic mdu_run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit indep);
    set_r(f, a, b);
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      if (indep && i == 0) begin
        set_r(F_ADD, 32'd3, 32'd4);
        alu_op = 2'b00;
        expect_sig(S_STALL, 32'd0);
        expect_sig(S_ALU, 32'd7);
      end else begin
        set_r(F_MFHI, 32'd0, 32'd0);
        expect_sig(S_STALL, 32'd1);
      end
      step();
    end
    set_r(F_MFLO, 32'd0, 32'd0);
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, exp_lo);
    step();
    set_r(F_MFHI, 32'd0, 32'd0);
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, exp_hi);
    step();
  endtask

  initial begin
    rst = 1'b1;
    pc = 32'd0; rt = 5'd3; rd = 5'd9; exmem_result = 32'd0; memwb_result = 32'd0;
    set_r(F_MFHI, 32'd0, 32'd0);
    #1;
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, 32'd0);
    step();
    step();
    rst = 1'b0;

    set_r(F_MFLO, 32'd0, 32'd0);
    expect_sig(S_ALU, 32'd0);
    expect_sig(S_STALL, 32'd0);
    step();

    set_r(F_SLT, 32'hFFFF_FFFF, 32'd1);
    expect_sig(S_ALU, 32'd1);
    step();
    set_r(F_SLTU, 32'hFFFF_FFFF, 32'd1);
    expect_sig(S_ALU, 32'd0);
    expect_sig(S_ZERO, 32'd1);
    step();

    set_r(F_ADD, 32'hDEAD_0000, 32'd1);
    fwd_a = 2'b10; exmem_result = 32'h1234;
    expect_sig(S_ALU, 32'h1235);
    step();

    set_r(F_ADD, 32'd0, 32'd5);
    fwd_b = 2'b01; memwb_result = 32'hCAFE_F00D; alu_src = 1'b1; imm = 32'd4;
    expect_sig(S_SD, 32'hCAFE_F00D);
    expect_sig(S_ALU, 32'd4);
    step();

    set_r(F_ADD, 32'd0, 32'd0);
    imm = 32'hFFFF_FFFF; pc = 32'h100;
    expect_sig(S_BT, 32'h0000_00FC);
    step();

    set_r(F_ADD, 32'd7, 32'd7);
    alu_op = 2'b01;
    expect_sig(S_ZERO, 32'd1);
    expect_sig(S_ALU, 32'd0);
    step();

    set_r(F_ADD, 32'h20, 32'd0);
    alu_op = 2'b00; alu_src = 1'b1; imm = 32'hFFFF_FFF0;
    expect_sig(S_ALU, 32'h10);
    expect_sig(S_WR, 32'd9);
    reg_dst = 1'b1;
    step();
    reg_dst = 1'b0; alu_op = 2'b11;
    expect_sig(S_WR, 32'd3);
    expect_sig(S_ALU, 32'h10);
    step();

    set_r(F_SRA, 32'd0, 32'h8000_0010); imm = 32'd4 << 6;
    expect_sig(S_ALU, 32'hF800_0001);
    step();
    set_r(F_SRL, 32'd0, 32'h8000_0010); imm = 32'd4 << 6;
    expect_sig(S_ALU, 32'h0800_0001);
    step();
    set_r(F_SLL, 32'd0, 32'd1); imm = 32'd31 << 6;
    expect_sig(S_ALU, 32'h8000_0000);
    step();
    set_r(F_NOR, 32'h0F0F_0000, 32'h00FF_0000);
    expect_sig(S_ALU, 32'hF000_FFFF);
    step();
    set_r(6'h3F, 32'h1, 32'h2);
    expect_sig(S_ALU, 32'd0);
    expect_sig(S_ZERO, 32'd1);
    step();

    mdu_run(F_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    mdu_run(F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    mdu_run(F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    mdu_run(F_DIVU,  32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    mdu_run(F_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    mdu_run(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    mdu_run(F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // A multu arriving while busy stalls, then starts once busy drops.
    set_r(F_MULT, 32'd5, 32'd5);
    expect_sig(S_STALL, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      set_r(F_MULTU, 32'hFFFF_FFFF, 32'd2);
      expect_sig(S_STALL, 32'd1);
      expect_sig(S_ALU, 32'd0);
      step();
    end
    mdu_run(F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

    // Reset at busy cycle 10 aborts the op and clears HI/LO.
    set_r(F_MULT, 32'd3, 32'd5);
    expect_sig(S_STALL, 32'd0);
    step();
    for (int i = 0; i < 9; i++) begin
      set_r(F_MFHI, 32'd0, 32'd0);
      expect_sig(S_STALL, 32'd1);
      expect_sig(S_ALU, 32'd1);
      step();
    end
    set_r(F_MFHI, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, 32'd0);
    step();
    rst = 1'b0;
    set_r(F_MFHI, 32'd0, 32'd0);
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, 32'd0);
    step();
    set_r(F_MFLO, 32'd0, 32'd0);
    expect_sig(S_STALL, 32'd0);
    expect_sig(S_ALU, 32'd0);
    step();
    step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
